// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: operation codes, FSM states and
// opcode class helpers.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_AND   = 4'b0000,
    OP_OR    = 4'b0001,
    OP_ADD   = 4'b0010,
    OP_SUB   = 4'b0011,
    OP_XOR   = 4'b0100,
    OP_SLL   = 4'b0101,
    OP_SRL   = 4'b0110,
    OP_SLT   = 4'b0111,
    OP_SRA   = 4'b1000,
    OP_SLTU  = 4'b1001,
    OP_MUL   = 4'b1010,
    OP_MULHU = 4'b1011,
    OP_DIVU  = 4'b1100,
    OP_REMU  = 4'b1101,
    OP_RSV0  = 4'b1110,
    OP_RSV1  = 4'b1111
  } aluop_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } state_e;

  function automatic logic is_mul_op(logic [3:0] op);
    return (op == OP_MUL) || (op == OP_MULHU);
  endfunction

  function automatic logic is_div_op(logic [3:0] op);
    return (op == OP_DIVU) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/response bus of the sequential ALU.
// Handshake: an operation transfers on a rising edge with in_valid && in_ready,
// a result transfers on a rising edge with out_valid && out_ready; a raised
// valid and its payload stay stable until the matching ready is seen.
interface alu_seq_if #(parameter int XLEN = 32);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] data1;
  logic [XLEN-1:0] data2;
  logic [3:0]      aluop;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] alu_result;
  logic            zero;
  logic            busy;

  modport master (
    output in_valid, data1, data2, aluop, out_ready,
    input  in_ready, out_valid, alu_result, zero, busy
  );

  modport slave (
    input  in_valid, data1, data2, aluop, out_ready,
    output in_ready, out_valid, alu_result, zero, busy
  );
endinterface

// File: rtl/alu_core.sv
// Combinational single-cycle ALU operations; iterative and reserved opcodes
// yield zero here.
module alu_core
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] data1,
  input  logic [XLEN-1:0] data2,
  input  logic [3:0]      aluop,
  output logic [XLEN-1:0] result
);

  localparam int SW = $clog2(XLEN);

  logic [SW-1:0] shamt;
  assign shamt = data2[SW-1:0];

  always_comb begin
    result = '0;
    case (aluop_e'(aluop))
      OP_AND:  result = data1 & data2;
      OP_OR:   result = data1 | data2;
      OP_ADD:  result = data1 + data2;
      OP_SUB:  result = data1 - data2;
      OP_XOR:  result = data1 ^ data2;
      OP_SLL:  result = data1 << shamt;
      OP_SRL:  result = data1 >> shamt;
      OP_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(data1) < $signed(data2))};
      OP_SRA:  result = $unsigned($signed(data1) >>> shamt);
      OP_SLTU: result = {{(XLEN-1){1'b0}}, (data1 < data2)};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle ops via alu_core, MUL/MULHU by shift-add and
// DIVU/REMU by restoring division, one bit per cycle over a shared register.
module alu_seq
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic        clk,
  input  logic        rst,
  alu_seq_if.slave    bus,
  output state_e      state_dbg
);

  localparam int CW = $clog2(XLEN) + 1;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q;
  logic [2*XLEN-1:0] work_q, work_nxt;
  logic [XLEN-1:0]   opb_q;
  logic              sel_hi_q;
  logic              out_valid_q, zero_q;
  logic [XLEN-1:0]   result_q, core_result, iter_result;
  logic              accept, single_op, last_iter;
  logic [XLEN:0]     mul_sum, rem_sh, rem_sub;

  alu_core #(.XLEN(XLEN)) u_core (
    .data1  (bus.data1),
    .data2  (bus.data2),
    .aluop  (bus.aluop),
    .result (core_result)
  );

  assign bus.in_ready   = (state_q == IDLE) && (!out_valid_q || bus.out_ready);
  assign bus.out_valid  = out_valid_q;
  assign bus.alu_result = result_q;
  assign bus.zero       = zero_q;
  assign bus.busy       = (state_q != IDLE);
  assign state_dbg      = state_q;

  assign accept    = bus.in_valid && bus.in_ready;
  assign single_op = !is_mul_op(bus.aluop) && !is_div_op(bus.aluop);
  assign last_iter = (state_q != IDLE) && (cnt_q == CW'(XLEN - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) begin
        if (is_mul_op(bus.aluop))      state_d = MUL;
        else if (is_div_op(bus.aluop)) state_d = DIV;
      end
      MUL, DIV: if (last_iter) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Upper half holds the partial product / remainder, lower half the
  // multiplier / dividend being consumed and the quotient being formed.
  always_comb begin
    mul_sum  = {1'b0, work_q[2*XLEN-1:XLEN]} + (work_q[0] ? {1'b0, opb_q} : '0);
    rem_sh   = {work_q[2*XLEN-1:XLEN], work_q[XLEN-1]};
    rem_sub  = rem_sh - {1'b0, opb_q};
    work_nxt = work_q;
    if (state_q == MUL) begin
      work_nxt = {mul_sum, work_q[XLEN-1:1]};
    end else if (state_q == DIV) begin
      if (!rem_sub[XLEN]) work_nxt = {rem_sub[XLEN-1:0], work_q[XLEN-2:0], 1'b1};
      else                work_nxt = {rem_sh[XLEN-1:0], work_q[XLEN-2:0], 1'b0};
    end
    iter_result = sel_hi_q ? work_nxt[2*XLEN-1:XLEN] : work_nxt[XLEN-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      work_q      <= '0;
      opb_q       <= '0;
      sel_hi_q    <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
    end else begin
      if (accept) begin
        opb_q    <= bus.data2;
        work_q   <= {{XLEN{1'b0}}, bus.data1};
        cnt_q    <= '0;
        sel_hi_q <= (bus.aluop == OP_MULHU) || (bus.aluop == OP_REMU);
      end else if (state_q != IDLE) begin
        work_q <= work_nxt;
        cnt_q  <= last_iter ? '0 : cnt_q + CW'(1);
      end

      if (accept && single_op) begin
        result_q    <= core_result;
        zero_q      <= (core_result == '0);
        out_valid_q <= 1'b1;
      end else if (last_iter) begin
        result_q    <= iter_result;
        zero_q      <= (iter_result == '0);
        out_valid_q <= 1'b1;
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width in bits (legal: 8, 16, 32, 64).
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1, operation request valid.
REQ-005 SHALL have port in_ready, output, 1, block can accept an operation this cycle.
REQ-006 SHALL have port data1, input, XLEN, operand A.
REQ-007 SHALL have port data2, input, XLEN, operand B (shift amount = low log2(XLEN) bits).
REQ-008 SHALL have port aluop, input, 4, operation code.
REQ-009 SHALL have port out_valid, output, 1, result valid.
REQ-010 SHALL have port out_ready, input, 1, consumer accepts result.
REQ-011 SHALL have port alu_result, output, XLEN, registered result.
REQ-012 SHALL have port zero, output, 1, registered (alu_result == 0).
REQ-013 SHALL have port busy, output, 1, high while an iterative operation is in progress.

Function
REQ-014 aluop encoding SHALL be: 0000 AND, 0001 OR, 0010 ADD, 0011 SUB, 0100 XOR, 0101 SLL, 0110 SRL, 0111 SLT (signed), 1000 SRA, 1001 SLTU, 1010 MUL (low XLEN), 1011 MULHU (high XLEN, unsigned), 1100 DIVU, 1101 REMU, 1110/1111 reserved.
REQ-015 Arithmetic SHALL wrap modulo 2^XLEN; SLT/SLTU results SHALL be 0 or 1 zero-extended.
REQ-016 Reserved opcodes SHALL complete as single-cycle ops with alu_result = 0, zero = 1.
REQ-017 Transfer in SHALL occur on an edge where in_valid && in_ready; transfer out on an edge where out_valid && out_ready.
REQ-018 in_ready SHALL equal (state == IDLE) && (!out_valid || out_ready), combinationally.
REQ-019 State machine SHALL have states IDLE, MUL, DIV; accepting aluop 1010/1011 goes IDLE->MUL, 1100/1101 goes IDLE->DIV, all others stay IDLE.
REQ-020 Single-cycle ops SHALL load alu_result/zero and set out_valid on the accepting edge (latency 1).
REQ-021 MUL SHALL be unsigned shift-add, DIV restoring shift-subtract, one bit per cycle, XLEN-bit iteration counter.
REQ-022 Iterative ops SHALL set out_valid exactly XLEN edges after the accepting edge, operand-independent, then return to IDLE on that edge.
REQ-023 DIVU by zero SHALL return all ones; REMU by zero SHALL return data1; latency unchanged.
REQ-024 out_valid, alu_result and zero SHALL hold stable while out_valid && !out_ready.
REQ-025 out_valid SHALL clear on transfer out unless a new result loads on the same edge (back-to-back allowed).
REQ-026 Inputs SHALL be ignored when !in_ready; operands SHALL be captured at acceptance, later input changes have no effect.
REQ-027 busy SHALL be high exactly when state is MUL or DIV.

Reset
REQ-028 While rst is high, state SHALL be IDLE, out_valid 0, alu_result 0, zero 0, busy 0, counter 0, asynchronously.
REQ-029 Reset during an iterative op SHALL abandon it; no result SHALL emerge after release.
REQ-030 in_ready SHALL be 1 on the first cycle after rst deasserts.

Structure
REQ-031 Package alu_pkg SHALL hold the aluop_e enum (REQ-014 codes) and the state_e enum.
REQ-032 Single-cycle ops SHALL live in combinational sub-module alu_core (data1, data2, aluop -> result), parametrised by XLEN.
REQ-033 MUL and DIV SHALL share one XLEN-bit counter and one 2*XLEN-bit working register.

Verification (XLEN=32)
REQ-034 ADD 0x1 + 0x2, out_ready=1 -> out_valid next cycle, result 0x3, zero 0; SUB 0x3 - 0x3 -> 0x0, zero 1.
REQ-035 MUL 0x0001_0000 x 0x0001_0000 -> 0x0, zero 1; MULHU same operands -> 0x1; out_valid exactly 32 edges after acceptance, busy 1 and in_ready 0 throughout.
REQ-036 DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU 5/0 -> 0xFFFF_FFFF; REMU 5/0 -> 0x5.
REQ-037 SRA 0x8000_0000 by 4 -> 0xF800_0000; SLT 0xFFFF_FFFF vs 0x1 -> 1; SLTU same -> 0; aluop 1111 -> 0, zero 1.
REQ-038 out_ready=0 after ADD -> result held 5 cycles, in_ready 0; raise out_ready with new in_valid -> old result drains and new op accepted on the same edge.
REQ-039 rst pulse during DIVU iteration 10 -> out_valid stays 0, busy 0, in_ready 1 after release, no stale result.
